// File: rtl/wfi_sleep_ctrl.sv
// wfi_sleep_ctrl: WFI sleep sequencer. It drains outstanding fetch and memory
// traffic, gates the core clock while asleep, and wakes on any pending source.
// Optional feature macro: WFI_SLEEP_CTRL_STATS_EN enables the sleep_cycles counter.
module wfi_sleep_ctrl #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned DRAIN_TIMEOUT = 16,
    parameter int unsigned WAKE_CYCLES   = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wfi_retire,
    input  logic            excpt,
    input  logic            debug,
    input  logic            single_step,
    input  logic            fetch_outstanding,
    input  logic            mem_outstanding,
    input  logic [XLEN-1:0] reg_mie,
    input  logic [XLEN-1:0] reg_mip,
    input  logic            bus_err_int,
    input  logic            debug_int,
    input  logic            clint_int,
    output logic            wfi,
    output logic            core_clock_en,
    output logic            wake_pulse,
    output logic            wfi_busy,
    output logic [31:0]     sleep_cycles
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SLEEP, ST_WAKE} state_t;

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0] WAKE_LAST  = 4'(WAKE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] drain_cnt, drain_cnt_nxt;
    logic [3:0] wake_cnt, wake_cnt_nxt;
    logic       pend;

    assign pend = (|(reg_mie & reg_mip)) | bus_err_int | debug_int | clint_int;

    // Next-state and counter logic; counters stop at their limit because the FSM exits there
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        wake_cnt_nxt  = wake_cnt;
        case (state)
            ST_IDLE: begin
                if (wfi_retire && !pend && !excpt && !debug && !single_step) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = '0;
                end
            end
            ST_DRAIN: begin
                if (pend || excpt || debug)
                    state_nxt = ST_IDLE;
                else if (!fetch_outstanding && !mem_outstanding)
                    state_nxt = ST_SLEEP;
                else if (drain_cnt == DRAIN_LAST)
                    state_nxt = ST_IDLE;
                else
                    drain_cnt_nxt = drain_cnt + 8'd1;
            end
            ST_SLEEP: begin
                if (pend || debug) begin
                    state_nxt    = ST_WAKE;
                    wake_cnt_nxt = '0;
                end
            end
            ST_WAKE: begin
                if (wake_cnt == WAKE_LAST)
                    state_nxt = ST_IDLE;
                else
                    wake_cnt_nxt = wake_cnt + 4'd1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counters and registered output decodes of the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            drain_cnt     <= '0;
            wake_cnt      <= '0;
            wfi           <= 1'b0;
            core_clock_en <= 1'b1;
            wake_pulse    <= 1'b0;
            wfi_busy      <= 1'b0;
        end else begin
            state         <= state_nxt;
            drain_cnt     <= drain_cnt_nxt;
            wake_cnt      <= wake_cnt_nxt;
            wfi           <= (state_nxt == ST_SLEEP);
            core_clock_en <= (state_nxt != ST_SLEEP);
            wake_pulse    <= (state == ST_SLEEP) && (state_nxt == ST_WAKE);
            wfi_busy      <= (state_nxt != ST_IDLE);
        end
    end

`ifdef WFI_SLEEP_CTRL_STATS_EN
    logic [31:0] sleep_cnt;

    // Saturating count of cycles spent with wfi asserted; only reset clears it
    always_ff @(posedge clock) begin
        if (reset)
            sleep_cnt <= '0;
        else if (wfi && (sleep_cnt != '1))
            sleep_cnt <= sleep_cnt + 32'd1;
    end

    assign sleep_cycles = sleep_cnt;
`else
    assign sleep_cycles = '0;
`endif

endmodule
